// File: rtl/msrv32_imm_encoder_if.sv
// msrv32_imm_encoder_if: input and output handshakes of the
// immediate encoder, with producer/consumer views.
interface msrv32_imm_encoder_if #(
  parameter int CNT_W = 8
);
  logic             in_valid_in;
  logic             in_ready_out;
  logic [31:0]      imm_in;
  logic [2:0]       imm_type_in;
  logic [24:0]      base_in;
  logic             out_valid_out;
  logic             out_ready_in;
  logic [24:0]      instr_out;
  logic             err_out;
  logic [CNT_W-1:0] err_cnt_out;

  modport master (
    output in_valid_in,
    output imm_in,
    output imm_type_in,
    output base_in,
    output out_ready_in,
    input  in_ready_out,
    input  out_valid_out,
    input  instr_out,
    input  err_out,
    input  err_cnt_out
  );

  modport slave (
    input  in_valid_in,
    input  imm_in,
    input  imm_type_in,
    input  base_in,
    input  out_ready_in,
    output in_ready_out,
    output out_valid_out,
    output instr_out,
    output err_out,
    output err_cnt_out
  );
endinterface

// File: rtl/msrv32_imm_encoder.sv
// msrv32_imm_encoder: two-stage pipeline scattering an immediate
// into instruction bits [31:7], flagging unrepresentable values.
module msrv32_imm_encoder #(
  parameter int CNT_W = 8
) (
  input logic clk_in,
  input logic rst_n_in,
  msrv32_imm_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_CSR = 3'd5
  } fmt_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1_valid;
  logic [31:0]      s1_imm;
  fmt_e             s1_fmt;
  logic [24:0]      s1_base;
  logic             s1_err;

  logic             s2_valid;
  logic [24:0]      s2_instr;
  logic             s2_err;
  logic [CNT_W-1:0] err_cnt;

  fmt_e             in_fmt;
  logic             in_err;
  logic [24:0]      packed_instr;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             out_fire;

  logic             sx_11;
  logic             sx_12;
  logic             sx_20;
  logic             low_zero;
  logic             high_zero;

  assign s2_free  = !s2_valid || bus.out_ready_in;
  assign s1_adv   = s1_valid && s2_free;
  assign accept   = bus.in_valid_in && bus.in_ready_out;
  assign out_fire = s2_valid && bus.out_ready_in;

  assign bus.in_ready_out  = !s1_valid || s2_free;
  assign bus.out_valid_out = s2_valid;
  assign bus.instr_out     = s2_instr;
  assign bus.err_out       = s2_err;
  assign bus.err_cnt_out   = err_cnt;

  // Fold the reserved type codes onto the I format.
  always_comb begin
    in_fmt = FMT_I;
    case (bus.imm_type_in)
      3'd1:    in_fmt = FMT_S;
      3'd2:    in_fmt = FMT_B;
      3'd3:    in_fmt = FMT_U;
      3'd4:    in_fmt = FMT_J;
      3'd5:    in_fmt = FMT_CSR;
      default: in_fmt = FMT_I;
    endcase
  end

  // Sign-extension and zero tests feeding the range check.
  always_comb begin
    sx_11 = (&bus.imm_in[31:11]) | ~(|bus.imm_in[31:11]);
    sx_12 = (&bus.imm_in[31:12]) | ~(|bus.imm_in[31:12]);
    sx_20 = (&bus.imm_in[31:20]) | ~(|bus.imm_in[31:20]);
    low_zero  = ~(|bus.imm_in[11:0]);
    high_zero = ~(|bus.imm_in[31:5]);
  end

  // Representability of the incoming immediate.
  always_comb begin
    in_err = 1'b0;
    unique case (1'b1)
      (in_fmt == FMT_I),
      (in_fmt == FMT_S):   in_err = !sx_11;
      (in_fmt == FMT_B):   in_err = !sx_12 || bus.imm_in[0];
      (in_fmt == FMT_U):   in_err = !low_zero;
      (in_fmt == FMT_J):   in_err = !sx_20 || bus.imm_in[0];
      (in_fmt == FMT_CSR): in_err = !high_zero;
      default:             in_err = 1'b0;
    endcase
  end

  // Scatter the S1 immediate over the template; index k is
  // instruction bit k+7.
  always_comb begin
    packed_instr = s1_base;
    unique case (1'b1)
      (s1_fmt == FMT_S): begin
        packed_instr[24:18] = s1_imm[11:5];
        packed_instr[4:0]   = s1_imm[4:0];
      end
      (s1_fmt == FMT_B): begin
        packed_instr[24]    = s1_imm[12];
        packed_instr[23:18] = s1_imm[10:5];
        packed_instr[4:1]   = s1_imm[4:1];
        packed_instr[0]     = s1_imm[11];
      end
      (s1_fmt == FMT_U): begin
        packed_instr[24:5]  = s1_imm[31:12];
      end
      (s1_fmt == FMT_J): begin
        packed_instr[24]    = s1_imm[20];
        packed_instr[23:14] = s1_imm[10:1];
        packed_instr[13]    = s1_imm[11];
        packed_instr[12:5]  = s1_imm[19:12];
      end
      (s1_fmt == FMT_CSR): begin
        packed_instr[12:8]  = s1_imm[4:0];
      end
      default: begin
        packed_instr[24:13] = s1_imm[11:0];
      end
    endcase
  end

  // Stage 1: capture accepted beats, empty when moving on.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_fmt   <= FMT_I;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_imm   <= bus.imm_in;
      s1_fmt   <= in_fmt;
      s1_base  <= bus.base_in;
      s1_err   <= in_err;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: packed result, held until the consumer takes it.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_instr <= packed_instr;
      s2_err   <= s1_err;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Saturating count of erroneous beats taken at the output.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      err_cnt <= '0;
    end else if (out_fire && s2_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule
